// File: rtl/hello_scroller_if.sv
// -----------------------------------------------------------------------------
// hello_scroller_if
//
// Bundles the control inputs and display outputs of hello_scroller so the
// sequencer and whoever drives it share one connection point.
//
// Signals (named from the sequencer's point of view):
//   run_i      1   level: 1 = auto-scroll from the prescaler, 0 = paused
//   step_i     1   asynchronous single-step button level (active-high)
//   letters_o  24  eight 3-bit letter codes, [23:21] = HEX7 ... [2:0] = HEX0
//   index_o    3   message index of the next character to enter at HEX0
//   filled_o   1   high once the window has been completely loaded
//
// Modports:
//   slave  - the sequencer (consumes run/step, produces letters/index/filled)
//   master - the controlling side (drives run/step, observes the display)
// -----------------------------------------------------------------------------
interface hello_scroller_if;
  logic        run_i;
  logic        step_i;
  logic [23:0] letters_o;
  logic [2:0]  index_o;
  logic        filled_o;

  modport slave (
    input  run_i,
    input  step_i,
    output letters_o,
    output index_o,
    output filled_o
  );

  modport master (
    output run_i,
    output step_i,
    input  letters_o,
    input  index_o,
    input  filled_o
  );
endinterface

// File: rtl/hello_scroller.sv
// -----------------------------------------------------------------------------
// hello_scroller
//
// Holds an eight-character window over the circular message
// "HELLO" + three blanks and shifts it left by one character per advance.
// Each 3-bit slot of letters_o feeds one per-digit letter decoder.
//
// Advances come from one of two sources, never both in the same cycle:
//   - run_i = 1 : a 26-bit prescaler fires once every TICKS clock cycles
//   - run_i = 0 : a rising edge of the step button, after a two-flop
//                 synchroniser plus one delay flop for edge detection
//
// A two-state FSM (FILL -> SCROLL) raises filled_o on the eighth advance
// after reset; once in SCROLL it only leaves through reset.
//
// Parameters:
//   TICKS     clock cycles per automatic scroll step, legal range 2..2^26
//
// Ports:
//   clk_i     system clock, all state updates on the rising edge
//   rst_ni    asynchronous active-low reset
//   bus       hello_scroller_if.slave: run_i, step_i in;
//             letters_o, index_o, filled_o out (all registered)
// -----------------------------------------------------------------------------
module hello_scroller #(
  parameter int unsigned TICKS = 50_000_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  hello_scroller_if.slave   bus
);

  // Letter codes understood by the downstream decoders.
  localparam logic [2:0] CH_H     = 3'h0;
  localparam logic [2:0] CH_E     = 3'h1;
  localparam logic [2:0] CH_L     = 3'h2;
  localparam logic [2:0] CH_O     = 3'h3;
  localparam logic [2:0] CH_BLANK = 3'h4;

  localparam logic [23:0] LETTERS_BLANK = {8{CH_BLANK}};

  // Terminal prescaler value; TICKS-1 always fits in 26 bits for the legal range.
  localparam logic [25:0] TICK_LAST = 26'(TICKS - 1);

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_SCROLL = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Message ROM: H E L L O _ _ _
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] msg_char(input logic [2:0] idx);
    logic [2:0] ch;
    ch = CH_BLANK;
    case (idx)
      3'd0:    ch = CH_H;
      3'd1:    ch = CH_E;
      3'd2:    ch = CH_L;
      3'd3:    ch = CH_L;
      3'd4:    ch = CH_O;
      default: ch = CH_BLANK;
    endcase
    return ch;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [25:0] count_q, count_d;
  logic        s1_q, s2_q, s3_q;
  logic [23:0] letters_q, letters_d;
  logic [2:0]  index_q, index_d;
  logic [2:0]  fill_q, fill_d;
  state_e      state_q, state_d;

  logic        step_edge;
  logic        tick_adv;
  logic        step_adv;
  logic        advance;

  // ---------------------------------------------------------------------------
  // Step button: s1/s2 synchronise the asynchronous level, s3 is the delayed
  // copy used to detect the rising edge. Holding the button produces a single
  // edge; a new edge needs s2 to have been low for at least one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.step_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign step_edge = s2_q & ~s3_q;

  // ---------------------------------------------------------------------------
  // Prescaler. Clearing while paused means resuming always waits a full
  // TICKS period. An edge that sees run_i high with the count at its last
  // value advances even if run_i drops right after that edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = '0;
    if (bus.run_i) begin
      if (count_q == TICK_LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + 26'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // run_i selects exactly one source, so the two terms can never both be set.
  assign tick_adv = bus.run_i & (count_q == TICK_LAST);
  assign step_adv = ~bus.run_i & step_edge;
  assign advance  = tick_adv | step_adv;

  // ---------------------------------------------------------------------------
  // Window datapath: shift left, new character enters at HEX0.
  // index wraps 7 -> 0 naturally in 3 bits, matching the 8-entry message.
  // ---------------------------------------------------------------------------
  always_comb begin
    letters_d = letters_q;
    index_d   = index_q;
    fill_d    = fill_q;
    if (advance) begin
      letters_d = {letters_q[20:0], msg_char(index_q)};
      index_d   = index_q + 3'd1;
      if (state_q == ST_FILL) begin
        fill_d = fill_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      letters_q <= LETTERS_BLANK;
      index_q   <= '0;
      fill_q    <= '0;
    end else begin
      letters_q <= letters_d;
      index_q   <= index_d;
      fill_q    <= fill_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. The eighth advance (fill count 7) completes the window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (advance && (fill_q == 3'd7)) begin
          state_d = ST_SCROLL;
        end
      end
      ST_SCROLL: begin
        state_d = ST_SCROLL;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // FSM: outputs. filled_o is a direct decode of the state flop, so it is
  // effectively registered and rises on the same edge as the eighth advance.
  always_comb begin
    bus.filled_o = 1'b0;
    case (state_q)
      ST_SCROLL: bus.filled_o = 1'b1;
      default:   bus.filled_o = 1'b0;
    endcase
  end

  assign bus.letters_o = letters_q;
  assign bus.index_o   = index_q;

endmodule
